// File: rtl/hack_pkg.sv
// Shared Hack-computer types and constants for the VRAM path.
package hack_pkg;

  localparam logic [14:0] SCREEN_BASE  = 15'h4000;
  localparam logic [14:0] SCREEN_LAST  = 15'h5FFF;
  localparam int unsigned SCREEN_WORDS = 8192;

  typedef logic [15:0]                       word_t;
  typedef logic [$clog2(SCREEN_WORDS)-1:0]   vram_addr_t;

  typedef enum logic [1:0] {IDLE, READ, WRITE} vram_arb_state_t;

  // One queued CPU screen store: 13-bit VRAM word address + 16-bit data.
  typedef struct packed {
    vram_addr_t addr;
    word_t      data;
  } wr_entry_t;

endpackage

// File: rtl/vram_wr_fifo.sv
// Small CPU write buffer; caller guarantees no push when full without a pop and no pop when empty.
module vram_wr_fifo
  import hack_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic                   pop,
  input  wr_entry_t              wdata,
  output wr_entry_t              head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  wr_entry_t         mem [DEPTH];
  logic [PW-1:0]     wptr;
  logic [PW-1:0]     rptr;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wdata;
  end

  assign head  = mem[rptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/vram_port_arbiter.sv
// Shares single-port VRAM between VGA scan-out reads (strict priority) and buffered CPU screen stores.
module vram_port_arbiter
  import hack_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned RAM_LAT    = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_we,
  input  logic [14:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic        cpu_stall,
  input  logic        vga_req,
  input  logic [12:0] vga_addr,
  output logic        vga_ack,
  output logic        vga_rvalid,
  output logic [15:0] vga_rdata,
  output logic [12:0] ram_addr,
  output logic [15:0] ram_data,
  output logic        ram_wren,
  input  logic [15:0] ram_q,
  output logic        wr_overflow
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  vram_arb_state_t      state;
  vram_arb_state_t      next_state;
  logic                 screen_store;
  logic                 push;
  logic                 pop;
  logic                 full;
  logic                 empty;
  logic [CW-1:0]        count;
  wr_entry_t            push_entry;
  wr_entry_t            head;
  logic [RAM_LAT-1:0]   vld_pipe;
  word_t                rdata_hold;

  // Screen window decode; low 13 bits of the offset are the VRAM word address.
  assign screen_store = cpu_we && (cpu_addr >= SCREEN_BASE) && (cpu_addr <= SCREEN_LAST);
  assign push         = screen_store && (!full || pop);
  assign push_entry   = '{addr: 13'(cpu_addr - SCREEN_BASE), data: cpu_wdata};
  assign cpu_stall    = (count == CW'(FIFO_DEPTH));

  vram_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .wdata   (push_entry),
    .head    (head),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  // Per-cycle grant: VGA read first, else drain one queued write.
  always_comb begin
    next_state = IDLE;
    pop        = 1'b0;
    if (vga_req) begin
      next_state = READ;
    end else if (!empty) begin
      next_state = WRITE;
      pop        = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      vga_ack     <= 1'b0;
      ram_wren    <= 1'b0;
      ram_addr    <= '0;
      ram_data    <= '0;
      wr_overflow <= 1'b0;
    end else begin
      state    <= next_state;
      vga_ack  <= (next_state == READ);
      ram_wren <= (next_state == WRITE);
      if (next_state == READ) begin
        ram_addr <= vga_addr;
      end else if (next_state == WRITE) begin
        ram_addr <= head.addr;
        ram_data <= head.data;
      end
      if (screen_store && full && !pop) wr_overflow <= 1'b1;
    end
  end

  // state==READ marks the cycle ram_addr carries a read address.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_pipe   <= '0;
      rdata_hold <= '0;
    end else begin
      vld_pipe <= RAM_LAT'({vld_pipe, (state == READ)});
      if (vga_rvalid) rdata_hold <= ram_q;
    end
  end

  assign vga_rvalid = vld_pipe[RAM_LAT-1];
  assign vga_rdata  = vga_rvalid ? ram_q : rdata_hold;

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Directed bench for vram_port_arbiter with a behavioural 1-cycle-latency VRAM.
module tb_vram_port_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cpu_we;
  logic [14:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_stall;
  logic        vga_req;
  logic [12:0] vga_addr;
  logic        vga_ack;
  logic        vga_rvalid;
  logic [15:0] vga_rdata;
  logic [12:0] ram_addr;
  logic [15:0] ram_data;
  logic        ram_wren;
  logic [15:0] ram_q;
  logic        wr_overflow;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] mem [8192];

  always #5 clk = ~clk;

  vram_port_arbiter #(.FIFO_DEPTH(4), .RAM_LAT(1)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_stall  (cpu_stall),
    .vga_req    (vga_req),
    .vga_addr   (vga_addr),
    .vga_ack    (vga_ack),
    .vga_rvalid (vga_rvalid),
    .vga_rdata  (vga_rdata),
    .ram_addr   (ram_addr),
    .ram_data   (ram_data),
    .ram_wren   (ram_wren),
    .ram_q      (ram_q),
    .wr_overflow(wr_overflow)
  );

  function automatic logic [15:0] pat(input logic [12:0] a);
    return {3'b101, a} ^ 16'h5A5A;
  endfunction

  // Read-before-write synchronous RAM model.
  always @(posedge clk) begin
    ram_q <= mem[ram_addr];
    if (ram_wren) mem[ram_addr] <= ram_data;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    cpu_we = 1'b0; vga_req = 1'b0;
    step(); step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({vga_ack, vga_rvalid, ram_wren, cpu_stall, wr_overflow} !== 5'b0) begin
      n_bad++; $display("FAIL reset_flags got=%b exp=00000",
                        {vga_ack, vga_rvalid, ram_wren, cpu_stall, wr_overflow});
    end
    n_cmp++;
    if ({ram_addr, ram_data, vga_rdata} !== 45'h0) begin
      n_bad++; $display("FAIL reset_buses addr=%h data=%h rdata=%h exp=0", ram_addr, ram_data, vga_rdata);
    end
  endtask

  task automatic test_single_write();
    cpu_we = 1'b1; cpu_addr = 15'h4000; cpu_wdata = 16'hFFFF;
    step();
    cpu_we = 1'b0;
    n_cmp++;
    if (ram_wren !== 1'b0) begin n_bad++; $display("FAIL wr1_early wren=%b exp=0", ram_wren); end
    step();
    n_cmp++;
    if ({ram_wren, ram_addr, ram_data} !== {1'b1, 13'h0000, 16'hFFFF}) begin
      n_bad++; $display("FAIL wr1_issue wren=%b addr=%h data=%h exp=1/0000/ffff", ram_wren, ram_addr, ram_data);
    end
    step();
    n_cmp++;
    if (ram_wren !== 1'b0) begin n_bad++; $display("FAIL wr1_oneshot wren=%b exp=0", ram_wren); end
  endtask

  task automatic test_vga_read();
    logic [12:0] exp_q[$];
    int acks = 0;
    int rvs  = 0;
    exp_q = '{13'h1234, 13'h1235, 13'h1236};
    vga_req = 1'b1; vga_addr = 13'h1234;
    for (int c = 0; c < 6; c++) begin
      step();
      if (c == 0) vga_addr = 13'h1235;
      if (c == 1) vga_addr = 13'h1236;
      if (c == 2) vga_req  = 1'b0;
      if (vga_ack) acks++;
      if (vga_rvalid) begin
        n_cmp++;
        if (rvs >= 3 || vga_rdata !== pat(exp_q[rvs])) begin
          n_bad++; $display("FAIL rd_data idx=%0d got=%h exp=%h", rvs, vga_rdata, pat(exp_q[rvs % 3]));
        end
        rvs++;
      end
    end
    n_cmp++;
    if (acks != 3) begin n_bad++; $display("FAIL rd_acks got=%0d exp=3", acks); end
    n_cmp++;
    if (rvs != 3) begin n_bad++; $display("FAIL rd_rvalids got=%0d exp=3", rvs); end
    n_cmp++;
    if (vga_rdata !== pat(13'h1236)) begin
      n_bad++; $display("FAIL rd_hold got=%h exp=%h", vga_rdata, pat(13'h1236));
    end
  endtask

  task automatic test_decode();
    int wrens = 0;
    cpu_we = 1'b1; cpu_addr = 15'h6000; cpu_wdata = 16'h1111;
    step();
    cpu_addr = 15'h3FFF; cpu_wdata = 16'h2222;
    step();
    cpu_we = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (ram_wren) wrens++;
      step();
    end
    n_cmp++;
    if (wrens != 0) begin n_bad++; $display("FAIL dec_ignore wrens=%0d exp=0", wrens); end
    cpu_we = 1'b1; cpu_addr = 15'h5FFF; cpu_wdata = 16'h1357;
    step();
    cpu_we = 1'b0;
    step();
    n_cmp++;
    if ({ram_wren, ram_addr, ram_data} !== {1'b1, 13'h1FFF, 16'h1357}) begin
      n_bad++; $display("FAIL dec_last wren=%b addr=%h data=%h exp=1/1fff/1357", ram_wren, ram_addr, ram_data);
    end
  endtask

  task automatic test_overflow();
    int idx = 0;
    vga_req = 1'b1; vga_addr = 13'h0010;
    for (int i = 0; i < 5; i++) begin
      cpu_we = 1'b1; cpu_addr = 15'(15'h4100 + i); cpu_wdata = 16'(16'hB000 + i);
      step();
      n_cmp++;
      if (cpu_stall !== (i >= 3)) begin
        n_bad++; $display("FAIL ovf_stall store=%0d got=%b exp=%b", i, cpu_stall, (i >= 3));
      end
      n_cmp++;
      if (wr_overflow !== (i == 4)) begin
        n_bad++; $display("FAIL ovf_flag store=%0d got=%b exp=%b", i, wr_overflow, (i == 4));
      end
    end
    cpu_we = 1'b0;
    n_cmp++;
    if (ram_wren !== 1'b0) begin n_bad++; $display("FAIL ovf_read_prio wren=%b exp=0", ram_wren); end
    vga_req = 1'b0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (ram_wren) begin
        n_cmp++;
        if (idx >= 4 || ram_addr !== 13'(13'h0100 + idx) || ram_data !== 16'(16'hB000 + idx)) begin
          n_bad++; $display("FAIL ovf_drain idx=%0d addr=%h data=%h exp=%h/%h", idx, ram_addr, ram_data,
                            13'(13'h0100 + idx), 16'(16'hB000 + idx));
        end
        idx++;
      end
    end
    n_cmp++;
    if (idx != 4) begin n_bad++; $display("FAIL ovf_drain_count got=%0d exp=4", idx); end
    n_cmp++;
    if ({cpu_stall, wr_overflow} !== 2'b01) begin
      n_bad++; $display("FAIL ovf_after stall/ovf=%b exp=01", {cpu_stall, wr_overflow});
    end
  endtask

  task automatic test_full_push_pop();
    int idx = 0;
    do_reset();
    vga_req = 1'b1; vga_addr = 13'h0020;
    for (int i = 0; i < 4; i++) begin
      cpu_we = 1'b1; cpu_addr = 15'(15'h4200 + i); cpu_wdata = 16'(16'hC000 + i);
      step();
    end
    n_cmp++;
    if (cpu_stall !== 1'b1) begin n_bad++; $display("FAIL pp_full stall=%b exp=1", cpu_stall); end
    vga_req = 1'b0; cpu_addr = 15'h4204; cpu_wdata = 16'hC004;
    step();
    cpu_we = 1'b0;
    n_cmp++;
    if ({cpu_stall, wr_overflow, ram_wren} !== 3'b101) begin
      n_bad++; $display("FAIL pp_same_cycle stall/ovf/wren=%b exp=101", {cpu_stall, wr_overflow, ram_wren});
    end
    for (int c = 0; c < 8; c++) begin
      if (ram_wren) begin
        n_cmp++;
        if (idx >= 5 || ram_addr !== 13'(13'h0200 + idx) || ram_data !== 16'(16'hC000 + idx)) begin
          n_bad++; $display("FAIL pp_drain idx=%0d addr=%h data=%h exp=%h/%h", idx, ram_addr, ram_data,
                            13'(13'h0200 + idx), 16'(16'hC000 + idx));
        end
        idx++;
      end
      step();
    end
    n_cmp++;
    if (idx != 5) begin n_bad++; $display("FAIL pp_drain_count got=%0d exp=5", idx); end
    n_cmp++;
    if (wr_overflow !== 1'b0) begin n_bad++; $display("FAIL pp_no_ovf got=%b exp=0", wr_overflow); end
  endtask

  task automatic test_reset_mid();
    int bad_ev = 0;
    vga_req = 1'b1; vga_addr = 13'h0030;
    cpu_we = 1'b1; cpu_addr = 15'h4300; cpu_wdata = 16'hD000;
    step();
    cpu_addr = 15'h4301; cpu_wdata = 16'hD001;
    step();
    cpu_we = 1'b0;
    step();
    n_cmp++;
    if ({vga_ack, vga_rvalid} !== 2'b11) begin
      n_bad++; $display("FAIL rst_pre ack/rvalid=%b exp=11", {vga_ack, vga_rvalid});
    end
    reset_n = 1'b0;
    vga_req = 1'b0;
    #1;
    n_cmp++;
    if ({vga_ack, vga_rvalid, ram_wren, cpu_stall, wr_overflow, ram_addr, ram_data, vga_rdata} !== 50'h0) begin
      n_bad++; $display("FAIL rst_async ack=%b rv=%b wren=%b addr=%h data=%h rdata=%h exp=all 0",
                        vga_ack, vga_rvalid, ram_wren, ram_addr, ram_data, vga_rdata);
    end
    step(); step();
    reset_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      if (vga_rvalid || ram_wren) bad_ev++;
    end
    n_cmp++;
    if (bad_ev != 0) begin n_bad++; $display("FAIL rst_after events=%0d exp=0", bad_ev); end
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = pat(13'(i));
    reset_n = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    vga_req = 1'b0; vga_addr = '0;
    step(); step();
    test_reset();
    reset_n = 1'b1;
    step();
    test_single_write();
    test_vga_read();
    test_decode();
    test_overflow();
    test_full_push_pop();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
